// File: rtl/ast_systolic_drain_v.sv
// Result reader for the 4x4 systolic MAC array: snapshots all 16 accumulators on
// capture, then streams them out one word per valid/ready beat, tagged with row/col/last.
module ast_systolic_drain_v #(
  parameter int DATAWIDTH = 16,
  parameter int ORDER     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 capture,
  input  logic [DATAWIDTH-1:0] din_0_0,
  input  logic [DATAWIDTH-1:0] din_0_1,
  input  logic [DATAWIDTH-1:0] din_0_2,
  input  logic [DATAWIDTH-1:0] din_0_3,
  input  logic [DATAWIDTH-1:0] din_1_0,
  input  logic [DATAWIDTH-1:0] din_1_1,
  input  logic [DATAWIDTH-1:0] din_1_2,
  input  logic [DATAWIDTH-1:0] din_1_3,
  input  logic [DATAWIDTH-1:0] din_2_0,
  input  logic [DATAWIDTH-1:0] din_2_1,
  input  logic [DATAWIDTH-1:0] din_2_2,
  input  logic [DATAWIDTH-1:0] din_2_3,
  input  logic [DATAWIDTH-1:0] din_3_0,
  input  logic [DATAWIDTH-1:0] din_3_1,
  input  logic [DATAWIDTH-1:0] din_3_2,
  input  logic [DATAWIDTH-1:0] din_3_3,
  output logic [DATAWIDTH-1:0] out_data,
  output logic [1:0]           out_row,
  output logic [1:0]           out_col,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t               state;
  logic [3:0]           index;
  logic [3:0]           next_index;
  logic [DATAWIDTH-1:0] snap    [16];
  logic [DATAWIDTH-1:0] din_arr [16];

  // Snapshot is always stored row-major (slot = 4*row + col).
  assign din_arr[0]  = din_0_0;
  assign din_arr[1]  = din_0_1;
  assign din_arr[2]  = din_0_2;
  assign din_arr[3]  = din_0_3;
  assign din_arr[4]  = din_1_0;
  assign din_arr[5]  = din_1_1;
  assign din_arr[6]  = din_1_2;
  assign din_arr[7]  = din_1_3;
  assign din_arr[8]  = din_2_0;
  assign din_arr[9]  = din_2_1;
  assign din_arr[10] = din_2_2;
  assign din_arr[11] = din_2_3;
  assign din_arr[12] = din_3_0;
  assign din_arr[13] = din_3_1;
  assign din_arr[14] = din_3_2;
  assign din_arr[15] = din_3_3;

  assign next_index = index + 4'd1;

  function automatic logic [1:0] idx_row(input logic [3:0] idx);
    return (ORDER != 0) ? idx[1:0] : idx[3:2];
  endfunction

  function automatic logic [1:0] idx_col(input logic [3:0] idx);
    return (ORDER != 0) ? idx[3:2] : idx[1:0];
  endfunction

  function automatic logic [3:0] idx_slot(input logic [3:0] idx);
    return {idx_row(idx), idx_col(idx)};
  endfunction

  // The first beat is loaded straight from din at the capture edge so out_valid rises one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      index     <= '0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < 16; i++) snap[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (capture) begin
            for (int i = 0; i < 16; i++) snap[i] <= din_arr[i];
            index     <= '0;
            state     <= STREAM;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= din_arr[idx_slot(4'd0)];
            out_row   <= idx_row(4'd0);
            out_col   <= idx_col(4'd0);
            out_last  <= 1'b0;
          end
        end
        STREAM: begin
          if (capture) overrun <= 1'b1;
          if (out_ready) begin
            if (index == 4'd15) begin
              state     <= DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              out_row   <= '0;
              out_col   <= '0;
              done      <= 1'b1;
            end else begin
              index    <= next_index;
              out_data <= snap[idx_slot(next_index)];
              out_row  <= idx_row(next_index);
              out_col  <= idx_col(next_index);
              out_last <= (next_index == 4'd15);
            end
          end
        end
        DONE: begin
          if (capture) overrun <= 1'b1;
          done  <= 1'b0;
          busy  <= 1'b0;
          index <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ast_systolic_drain_v.md
Name: ast_systolic_drain_v

Overview:
Result reader for the 4x4 systolic MAC array. It snapshots all 16 accumulator outputs (dout_R_C of the array) on a capture pulse. It then streams the snapshot out one word per beat over a valid/ready interface, tagged with row/column and a last flag. It sits between the array and the downstream result sink (DMA/writeback), so the array can start its next computation as soon as capture is taken.

Parameters:
DATAWIDTH, 16, width of each accumulator word and of the output data.
ORDER, 0, 0 = row-major drain (R outer, C inner); 1 = column-major drain (C outer, R inner).

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-low reset.
capture  input  1  single-cycle request to snapshot the array outputs and start draining.
din_R_C  input  DATAWIDTH  accumulator word from array element R,C; 16 ports, R,C in 0..3, connected to the array's dout_R_C.
out_data  output  DATAWIDTH  current result word.
out_row  output  2  row index of out_data.
out_col  output  2  column index of out_data.
out_last  output  1  high on the 16th (final) beat.
out_valid  output  1  out_data/out_row/out_col/out_last are valid.
out_ready  input  1  sink accepts the beat when out_valid and out_ready are both high.
busy  output  1  high whenever state is not IDLE.
done  output  1  one-cycle pulse after the last beat transfers.
overrun  output  1  sticky; set when capture arrives while busy.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, port named reset.
- Reset (reset=0): applies immediately, not waiting for a clock edge, including mid-stream.
  - All outputs go to 0, state goes to IDLE, index goes to 0, snapshot registers go to 0, overrun clears.
- State machine states: IDLE, STREAM, DONE.
- IDLE:
  - capture=1: all 16 din_R_C are registered into the snapshot on the same edge, index is set to 0, next state is STREAM.
  - capture=0: state stays IDLE, out_valid=0.
- STREAM:
  - out_valid=1, starting the cycle after capture (latency 1).
  - out_data = snapshot[index]. out_row and out_col are decoded from index. out_last = (index==15).
  - A beat transfers when out_valid and out_ready are both 1. On transfer, index increments.
  - When out_ready=0, all out_* signals hold stable and index is unchanged. No beat is ever dropped or duplicated.
  - When the beat with index 15 transfers, next state is DONE and out_valid drops to 0 in the following cycle.
- Back-to-back: with out_ready held high, 16 beats appear on 16 consecutive cycles.
- DONE: done=1 for exactly one cycle, out_valid=0, then state returns to IDLE. A capture can be accepted in the cycle after DONE.
- Index decode:
  - ORDER=0: row=index[3:2], col=index[1:0].
  - ORDER=1: col=index[3:2], row=index[1:0].
- Snapshot isolation: changes on din_* after the capture edge have no effect on the stream in progress.
- capture while in STREAM or DONE:
  - The capture is ignored and overrun is set to 1.
  - The stream in progress continues unaffected.
  - overrun stays 1 until reset.
- capture in the same cycle as the final beat transfers (still STREAM): treated as an overrun.
- busy = (state != IDLE), registered.
- Data is passed through bit-exact; no arithmetic, sign handling or truncation.

Test Plan:
- Reset values: assert reset=0 while clocking -> every output 0, busy=0. Release reset, hold capture=0 for 5 cycles -> out_valid stays 0.
- Row-major drain, ORDER=0:
  - Stimulus: din_R_C = 0x0100+4R+C, one-cycle capture, out_ready=1.
  - Response: out_valid high on cycles t+1..t+16. out_data runs 0x0100..0x010F, with row/col {0,0},{0,1},...,{3,3}.
  - out_last only on 0x010F. done pulses at t+17, busy falls at t+18.
- Backpressure: same stimulus, out_ready toggled 1,0,0,1 repeating -> exactly 16 transfers, in order. Values are held unchanged during every ready=0 cycle.
- Snapshot isolation: capture with din_R_C = 0x0100+4R+C, then drive all din to 0xFFFF the next cycle -> stream still outputs 0x0100..0x010F.
- Overrun: capture again at beat 5 -> overrun=1 and stays 1. The stream completes with the original 16 values and only one done pulse.
- Column-major and reset: ORDER=1 -> out_data sequence 0x0100,0x0104,0x0108,0x010C,0x0101,... with out_last on 0x010F. Separately, assert reset at beat 7 -> out_valid=0 immediately, then restart cleanly on the next capture.
